// File: rtl/axi_uart_bridge.sv
// AXI4-Lite responder giving register access to a UART byte stream through a TX and an RX FIFO.
// Optional feature macro: AXI_UART_IRQ_EN adds the irq output and the IRQ_EN register at addr 2.
module axi_uart_bridge #(
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_DEPTH_LOG2 = 4
) (
    input  logic        a_clk,
    input  logic        a_rst,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [17:0] aw_addr,
    input  logic [2:0]  aw_prot,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [15:0] w_data,
    input  logic [1:0]  w_strb,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_resp,
    input  logic        ar_valid,
    output logic        ar_ready,
    input  logic [17:0] ar_addr,
    input  logic [2:0]  ar_prot,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] r_data,
    output logic [1:0]  r_resp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
`ifdef AXI_UART_IRQ_EN
    output logic        irq,
`endif
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned TxDepth = 2 ** TX_DEPTH_LOG2;
    localparam int unsigned RxDepth = 2 ** RX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] TxOne = 1;
    localparam logic [RX_DEPTH_LOG2:0] RxOne = 1;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    // FIFO storage and pointers (one extra wrap bit separates full from empty)
    logic [7:0]               tx_mem [TxDepth];
    logic [7:0]               rx_mem [RxDepth];
    logic [TX_DEPTH_LOG2:0]   tx_wptr_q, tx_rptr_q;
    logic [RX_DEPTH_LOG2:0]   rx_wptr_q, rx_rptr_q;
    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic rx_ovf_q, ovf_set, ovf_clr;

    logic        wr_hs, rd_hs;
    logic        b_valid_q, b_valid_d, r_valid_q, r_valid_d;
    logic [1:0]  b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [15:0] r_data_q, r_data_d;
`ifdef AXI_UART_IRQ_EN
    logic [2:0]  irq_en_q, irq_en_d;
    logic        irq_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{aw_addr[17:2], aw_prot, ar_addr[17:2], ar_prot, w_data[15:8], w_strb[1]};

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TX_DEPTH_LOG2] != tx_rptr_q[TX_DEPTH_LOG2]) &&
                      (tx_wptr_q[TX_DEPTH_LOG2-1:0] == tx_rptr_q[TX_DEPTH_LOG2-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RX_DEPTH_LOG2] != rx_rptr_q[RX_DEPTH_LOG2]) &&
                      (rx_wptr_q[RX_DEPTH_LOG2-1:0] == rx_rptr_q[RX_DEPTH_LOG2-1:0]);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rptr_q[TX_DEPTH_LOG2-1:0]];
    assign tx_pop   = tx_valid && tx_ready;

    // A full RX FIFO still takes a byte when a read pops in the same cycle
    assign rx_ready = !a_rst;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign ovf_set  = rx_valid && rx_full && !rx_pop;

    // AW and W are taken together, only while no write response is pending
    assign wr_hs    = aw_valid && w_valid && !b_valid_q && !a_rst;
    assign aw_ready = wr_hs;
    assign w_ready  = wr_hs;
    assign rd_hs    = ar_valid && !r_valid_q && !a_rst;
    assign ar_ready = rd_hs;

    assign b_valid = b_valid_q;
    assign b_resp  = b_resp_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_resp  = r_resp_q;

    // Write decode: response, TX push, overflow clear, IRQ enables
    always_comb begin
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        tx_push   = 1'b0;
        ovf_clr   = 1'b0;
`ifdef AXI_UART_IRQ_EN
        irq_en_d  = irq_en_q;
`endif
        if (b_valid_q && b_ready) b_valid_d = 1'b0;
        if (wr_hs) begin
            b_valid_d = 1'b1;
            b_resp_d  = RespOkay;
            case (aw_addr[1:0])
                2'd0: begin
                    if (w_strb[0]) begin
                        if (tx_full && !tx_pop) b_resp_d = RespSlvErr;
                        else                    tx_push  = 1'b1;
                    end
                end
                2'd1: ovf_clr = w_data[4];
`ifdef AXI_UART_IRQ_EN
                2'd2: irq_en_d = w_data[2:0];
`endif
                default: b_resp_d = RespDecErr;
            endcase
        end
    end

    // Read decode: response data captured at the AR handshake, RX pop
    always_comb begin
        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        rx_pop    = 1'b0;
        if (r_valid_q && r_ready) r_valid_d = 1'b0;
        if (rd_hs) begin
            r_valid_d = 1'b1;
            r_resp_d  = RespOkay;
            r_data_d  = '0;
            case (ar_addr[1:0])
                2'd0: begin
                    if (!rx_empty) begin
                        r_data_d = {8'h80, rx_mem[rx_rptr_q[RX_DEPTH_LOG2-1:0]]};
                        rx_pop   = 1'b1;
                    end
                end
                2'd1: r_data_d = {11'b0, rx_ovf_q, rx_full, rx_empty, tx_empty, tx_full};
`ifdef AXI_UART_IRQ_EN
                2'd2: r_data_d = {13'b0, irq_en_q};
`endif
                default: r_resp_d = RespDecErr;
            endcase
        end
    end

    // Control state and FIFO pointers
    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= RespOkay;
            r_valid_q <= 1'b0;
            r_resp_q  <= RespOkay;
            r_data_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_ovf_q  <= 1'b0;
        end else begin
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
            if (tx_push) tx_wptr_q <= tx_wptr_q + TxOne;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxOne;
            if (rx_push) rx_wptr_q <= rx_wptr_q + RxOne;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RxOne;
            // set beats clear when both land in one cycle
            if (ovf_set)      rx_ovf_q <= 1'b1;
            else if (ovf_clr) rx_ovf_q <= 1'b0;
        end
    end

    // FIFO storage writes (contents need no reset)
    always_ff @(posedge a_clk) begin
        if (tx_push) tx_mem[tx_wptr_q[TX_DEPTH_LOG2-1:0]] <= w_data[7:0];
        if (rx_push) rx_mem[rx_wptr_q[RX_DEPTH_LOG2-1:0]] <= rx_data;
    end

`ifdef AXI_UART_IRQ_EN
    // Registered interrupt: OR of enabled rx-nonempty, tx-empty, overflow conditions
    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            irq_en_q <= 3'b000;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= |(irq_en_q & {rx_ovf_q, tx_empty, !rx_empty});
        end
    end
    assign irq = irq_q;
`endif

endmodule
